// File: rtl/sme_param.sv
// Parametrised string matcher: loads a string, then scores each pattern (^ $ . * wildcards) for match and leftmost index.
// Latency 2..2*(Ls+2)*(Lp+2) cycles from the first idle cycle after a pattern; no backpressure, strobes ignored while searching.
module sme_param #(
    parameter int CHAR_W  = 8,
    parameter int MAX_STR = 32,
    parameter int MAX_PAT = 8,
    parameter int IDX_W   = $clog2(MAX_STR)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CHAR_W-1:0] chardata,
    input  logic              isstring,
    input  logic              ispattern,
    input  logic              nocase,
    output logic              valid,
    output logic              match,
    output logic [IDX_W-1:0]  match_index,
    output logic              overflow
);
    localparam int SI_W = $clog2(MAX_STR);
    localparam int PI_W = $clog2(MAX_PAT);
    localparam int LS_W = $clog2(MAX_STR + 1);
    localparam int LP_W = $clog2(MAX_PAT + 1);
    localparam logic [LS_W-1:0]   STR_FULL = LS_W'(MAX_STR);
    localparam logic [LP_W-1:0]   PAT_FULL = LP_W'(MAX_PAT);
    localparam logic [CHAR_W-1:0] C_CARET  = CHAR_W'(8'h5E);
    localparam logic [CHAR_W-1:0] C_DOLLAR = CHAR_W'(8'h24);
    localparam logic [CHAR_W-1:0] C_DOT    = CHAR_W'(8'h2E);
    localparam logic [CHAR_W-1:0] C_STAR   = CHAR_W'(8'h2A);
    localparam logic [CHAR_W-1:0] C_SPACE  = CHAR_W'(8'h20);

    typedef enum logic [1:0] {IDLE, LOAD, SEARCH, DONE} state_t;

    state_t state, state_next;

    logic [CHAR_W-1:0] str_mem [MAX_STR];
    logic [CHAR_W-1:0] pat_mem [MAX_PAT];
    logic [LS_W-1:0]   str_len;
    logic [LP_W-1:0]   pat_len;
    logic              str_ovf, pat_ovf, prev_str, prev_pat, nocase_r;

    // start_i: candidate start for the prefix; base: candidate start for the suffix after '*'
    logic [LS_W-1:0]   start_i, base, sp, sp_m1;
    logic [LP_W-1:0]   pp, suf_pp;
    logic              phase;

    logic              loading, str_wr, pat_wr;
    logic [CHAR_W-1:0] pch, sch, prv;
    logic              pat_end, have_ch, is_star, step_ok, step_adv, retry_last;

    function automatic logic [CHAR_W-1:0] fold(input logic [CHAR_W-1:0] c);
        if (c >= CHAR_W'(8'h41) && c <= CHAR_W'(8'h5A))
            return c + CHAR_W'(8'h20);
        return c;
    endfunction

    assign loading = (state == IDLE) || (state == LOAD);
    assign str_wr  = loading && isstring && (!prev_str || str_len != STR_FULL);
    assign pat_wr  = loading && ispattern && (!prev_pat || pat_len != PAT_FULL);

    always_ff @(posedge clk) begin
        if (str_wr)
            str_mem[prev_str ? str_len[SI_W-1:0] : '0] <= chardata;
        if (pat_wr)
            pat_mem[prev_pat ? pat_len[PI_W-1:0] : '0] <= chardata;
    end

    // Full-width compares against str_len keep an index of MAX_STR from aliasing entry 0
    assign sp_m1      = sp - LS_W'(1);
    assign pch        = pat_mem[pp[PI_W-1:0]];
    assign sch        = str_mem[sp[SI_W-1:0]];
    assign prv        = str_mem[sp_m1[SI_W-1:0]];
    assign pat_end    = (pp == pat_len);
    assign have_ch    = (sp < str_len);
    assign retry_last = phase ? (base == str_len) : (start_i == str_len);

    always_comb begin
        is_star  = 1'b0;
        step_ok  = 1'b0;
        step_adv = 1'b0;
        if (pch == C_STAR) begin
            is_star = 1'b1;
        end else if (pch == C_CARET) begin
            step_ok = (sp == '0) || (prv == C_SPACE);
        end else if (pch == C_DOLLAR) begin
            step_ok = (sp == str_len) || (have_ch && sch == C_SPACE);
        end else if (pch == C_DOT) begin
            step_ok  = have_ch;
            step_adv = 1'b1;
        end else begin
            step_ok  = have_ch && (nocase_r ? (fold(sch) == fold(pch)) : (sch == pch));
            step_adv = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, LOAD: begin
                if (isstring || ispattern)
                    state_next = LOAD;
                else if (prev_pat)
                    state_next = SEARCH;
                else
                    state_next = IDLE;
            end
            SEARCH: if (pat_end || (!is_star && !step_ok && retry_last)) state_next = DONE;
            DONE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            str_len     <= '0;
            pat_len     <= '0;
            str_ovf     <= 1'b0;
            pat_ovf     <= 1'b0;
            prev_str    <= 1'b0;
            prev_pat    <= 1'b0;
            nocase_r    <= 1'b0;
            start_i     <= '0;
            base        <= '0;
            sp          <= '0;
            pp          <= '0;
            suf_pp      <= '0;
            phase       <= 1'b0;
            valid       <= 1'b0;
            match       <= 1'b0;
            match_index <= '0;
            overflow    <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE, LOAD: begin
                    prev_str <= isstring;
                    prev_pat <= ispattern;
                    if (isstring) begin
                        if (!prev_str) begin
                            str_len <= LS_W'(1);
                            str_ovf <= 1'b0;
                        end else if (str_len != STR_FULL) begin
                            str_len <= str_len + LS_W'(1);
                        end else begin
                            str_ovf <= 1'b1;
                        end
                    end
                    if (ispattern) begin
                        if (!prev_pat) begin
                            pat_len  <= LP_W'(1);
                            pat_ovf  <= 1'b0;
                            nocase_r <= nocase;
                        end else if (pat_len != PAT_FULL) begin
                            pat_len <= pat_len + LP_W'(1);
                        end else begin
                            pat_ovf <= 1'b1;
                        end
                    end
                    start_i <= '0;
                    base    <= '0;
                    sp      <= '0;
                    pp      <= '0;
                    suf_pp  <= '0;
                    phase   <= 1'b0;
                end
                SEARCH: begin
                    if (pat_end) begin
                        valid       <= 1'b1;
                        match       <= 1'b1;
                        match_index <= IDX_W'(start_i);
                        overflow    <= str_ovf | pat_ovf;
                    end else if (is_star) begin
                        phase  <= 1'b1;
                        base   <= sp;
                        pp     <= pp + LP_W'(1);
                        suf_pp <= pp + LP_W'(1);
                    end else if (step_ok) begin
                        pp <= pp + LP_W'(1);
                        if (step_adv)
                            sp <= sp + LS_W'(1);
                    end else if (retry_last) begin
                        valid       <= 1'b1;
                        match       <= 1'b0;
                        match_index <= '0;
                        overflow    <= str_ovf | pat_ovf;
                    end else if (phase) begin
                        // Suffix slides right; the prefix anchor is never revisited
                        base <= base + LS_W'(1);
                        sp   <= base + LS_W'(1);
                        pp   <= suf_pp;
                    end else begin
                        start_i <= start_i + LS_W'(1);
                        sp      <= start_i + LS_W'(1);
                        pp      <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sme_param.sv
// Scoreboard bench for sme_param: expected results queued per pattern, compared when valid pulses.
module tb_sme_param;
    localparam int CHAR_W  = 8;
    localparam int MAX_STR = 32;
    localparam int MAX_PAT = 8;
    localparam int IDX_W   = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic [CHAR_W-1:0] chardata;
    logic              isstring, ispattern, nocase;
    logic              valid, match, overflow;
    logic [IDX_W-1:0]  match_index;

    typedef struct {
        logic             m;
        logic [IDX_W-1:0] idx;
        logic             ovf;
        int               bound;
        string            name;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int vcount = 0;
    int cur_ls = 0;

    sme_param #(.CHAR_W(CHAR_W), .MAX_STR(MAX_STR), .MAX_PAT(MAX_PAT), .IDX_W(IDX_W)) dut (
        .clk(clk), .reset(reset), .chardata(chardata), .isstring(isstring),
        .ispattern(ispattern), .nocase(nocase), .valid(valid), .match(match),
        .match_index(match_index), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (valid === 1'b1) vcount <= vcount + 1;

    task automatic put_char(input logic [7:0] c, input bit s, input bit p, input bit nc);
        @(negedge clk);
        chardata = c; isstring = s; ispattern = p; nocase = nc;
    endtask

    task automatic idle();
        @(negedge clk);
        chardata = '0; isstring = 1'b0; ispattern = 1'b0; nocase = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) put_char(s[i], 1'b1, 1'b0, 1'b0);
        cur_ls = (s.len() > MAX_STR) ? MAX_STR : s.len();
        idle();
    endtask

    // Drives the pattern and its trailing idle cycle (the first cycle with both strobes low)
    task automatic send_pat(input string p, input bit nc, input logic m, input int idx,
                            input logic ovf, input string name);
        exp_t e;
        int lp;
        lp = (p.len() > MAX_PAT) ? MAX_PAT : p.len();
        e.m = m; e.idx = IDX_W'(idx); e.ovf = ovf; e.name = name;
        e.bound = 2 * (cur_ls + 2) * (lp + 2);
        sb.push_back(e);
        for (int i = 0; i < p.len(); i++) put_char(p[i], 1'b0, 1'b1, nc);
        idle();
    endtask

    task automatic wait_valid(input int bound, output int lat, output bit got);
        lat = 0; got = 1'b0;
        while (!got && lat < bound + 4) begin
            @(negedge clk);
            lat++;
            if (valid === 1'b1) got = 1'b1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; chardata = '0; isstring = 1'b0; ispattern = 1'b0; nocase = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        cur_ls = 0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
        checks++; if (match !== 1'b0) begin errors++; $display("FAIL reset_match got %b want 0", match); end
        checks++; if (match_index !== '0) begin errors++; $display("FAIL reset_index got %0d want 0", match_index); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
        checks++; if (vcount !== 0) begin errors++; $display("FAIL reset_no_pulse got %0d want 0", vcount); end
    endtask

    task automatic test_match();
        string pats [9] = '{"wor", "^wor", "o$", "l.o", "h*ld", "e*x", "^ell", "WOR", "WOR"};
        bit    ncs  [9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
        bit    ems  [9] = '{1, 1, 1, 1, 1, 0, 0, 1, 0};
        int    eis  [9] = '{6, 6, 4, 2, 0, 0, 0, 6, 0};
        exp_t e;
        int lat;
        bit got;
        send_str("hello world");
        for (int k = 0; k < 9; k++) begin
            send_pat(pats[k], ncs[k], ems[k], eis[k], 1'b0, pats[k]);
            wait_valid(sb[0].bound, lat, got);
            e = sb.pop_front();
            checks++; if (!got) begin errors++; $display("FAIL %s no valid within %0d cycles", e.name, lat); end
            checks++; if (match !== e.m) begin errors++; $display("FAIL %s match got %b want %b", e.name, match, e.m); end
            checks++; if (match_index !== e.idx) begin errors++; $display("FAIL %s index got %0d want %0d", e.name, match_index, e.idx); end
            checks++; if (overflow !== e.ovf) begin errors++; $display("FAIL %s overflow got %b want %b", e.name, overflow, e.ovf); end
            checks++; if (lat < 2 || lat > e.bound) begin errors++; $display("FAIL %s latency got %0d want 2..%0d", e.name, lat, e.bound); end
        end
    endtask

    task automatic test_overflow();
        string s;
        exp_t e;
        int lat;
        bit got;
        s = "";
        for (int i = 0; i < 40; i++) s = {s, "a"};
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                send_str(s);
                send_pat("b", 1'b0, 1'b0, 0, 1'b1, "ovf_long");
            end else begin
                send_str("abc");
                send_pat("c", 1'b0, 1'b1, 2, 1'b0, "ovf_clear");
            end
            wait_valid(sb[0].bound, lat, got);
            e = sb.pop_front();
            checks++; if (!got) begin errors++; $display("FAIL %s no valid within %0d cycles", e.name, lat); end
            checks++; if (match !== e.m) begin errors++; $display("FAIL %s match got %b want %b", e.name, match, e.m); end
            checks++; if (match_index !== e.idx) begin errors++; $display("FAIL %s index got %0d want %0d", e.name, match_index, e.idx); end
            checks++; if (overflow !== e.ovf) begin errors++; $display("FAIL %s overflow got %b want %b", e.name, overflow, e.ovf); end
            checks++; if (lat < 2 || lat > e.bound) begin errors++; $display("FAIL %s latency got %0d want 2..%0d", e.name, lat, e.bound); end
        end
    endtask

    task automatic test_reset_abort();
        exp_t e;
        int lat, v0;
        bit got;
        send_str("aaaaaaaa");
        put_char("b", 1'b0, 1'b1, 1'b0);
        idle();
        v0 = vcount;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cur_ls = 0;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %b want 0", valid); end
        checks++; if (match !== 1'b0) begin errors++; $display("FAIL abort_match got %b want 0", match); end
        checks++; if (match_index !== '0) begin errors++; $display("FAIL abort_index got %0d want 0", match_index); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL abort_overflow got %b want 0", overflow); end
        repeat (20) @(negedge clk);
        checks++; if (vcount !== v0) begin errors++; $display("FAIL abort_no_pulse got %0d pulses want 0", vcount - v0); end
        send_str("xy");
        send_pat("y", 1'b0, 1'b1, 1, 1'b0, "after_abort");
        wait_valid(sb[0].bound, lat, got);
        e = sb.pop_front();
        checks++; if (!got) begin errors++; $display("FAIL %s no valid within %0d cycles", e.name, lat); end
        checks++; if (match !== e.m) begin errors++; $display("FAIL %s match got %b want %b", e.name, match, e.m); end
        checks++; if (match_index !== e.idx) begin errors++; $display("FAIL %s index got %0d want %0d", e.name, match_index, e.idx); end
        checks++; if (overflow !== e.ovf) begin errors++; $display("FAIL %s overflow got %b want %b", e.name, overflow, e.ovf); end
    endtask

    task automatic test_back_to_back();
        string pats [3] = '{"b$", "^a", "."};
        int    eis  [3] = '{1, 0, 0};
        exp_t e;
        int lat, v0;
        bit got;
        send_str("ab ab");
        v0 = vcount;
        for (int k = 0; k < 3; k++) begin
            // Next pattern starts in the cycle right after the valid pulse
            send_pat(pats[k], 1'b0, 1'b1, eis[k], 1'b0, pats[k]);
            wait_valid(sb[0].bound, lat, got);
            e = sb.pop_front();
            checks++; if (!got) begin errors++; $display("FAIL b2b %s no valid within %0d cycles", e.name, lat); end
            checks++; if (match !== e.m) begin errors++; $display("FAIL b2b %s match got %b want %b", e.name, match, e.m); end
            checks++; if (match_index !== e.idx) begin errors++; $display("FAIL b2b %s index got %0d want %0d", e.name, match_index, e.idx); end
            checks++; if (lat < 2 || lat > e.bound) begin errors++; $display("FAIL b2b %s latency got %0d want 2..%0d", e.name, lat, e.bound); end
        end
        repeat (3) @(negedge clk);
        checks++; if (vcount - v0 !== 3) begin errors++; $display("FAIL b2b_pulses got %0d want 3", vcount - v0); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_drop got %b want 0", valid); end
    endtask

    initial begin
        test_reset();
        test_match();
        test_overflow();
        test_reset_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
